// File: rtl/spi_rom_pkg.sv
// -----------------------------------------------------------------------------
// spi_rom_pkg
// Shared definitions for the SPI ROM read arbiter: FSM state encoding, SPI
// flash opcodes, preamble field widths and a helper that builds the
// command/address word shifted out at the start of every read.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_rom_pkg;

  // FSM state enumeration (plain constants for legacy-tool compatibility)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CMD   = 3'd1;
  localparam state_t ST_ADDR  = 3'd2;
  localparam state_t ST_DUMMY = 3'd3;
  localparam state_t ST_DATA  = 3'd4;
  localparam state_t ST_GAP   = 3'd5;

  // SPI flash read opcodes
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  // Preamble field lengths in SPI bits
  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;
  localparam int PRE_BITS   = CMD_BITS + ADDR_BITS;

  // Opcode followed by the start address, MSB first on the wire
  function automatic logic [PRE_BITS-1:0] build_preamble(input logic [7:0]  op,
                                                          input logic [23:0] addr);
    return {op, addr};
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// -----------------------------------------------------------------------------
// spi_bit_engine
// Two-phase SPI bit timing plus the transmit/receive shift registers.
// Each bit lasts two clk cycles: phase 0 (sclk=0, mosi updated), phase 1
// (sclk=1). MISO is shifted in on the clk edge that ends phase 1.
// Ports:
//   clk, reset     : system clock, asynchronous active-high reset
//   i_start        : load i_word and raise chip select on the next edge
//   i_word[31:0]   : preamble (opcode + address), sent MSB first
//   i_stop         : end the transfer at the close of the current phase 1
//   i_miso         : serial data from the ROM
//   o_cs, o_sclk, o_mosi : registered SPI pins
//   o_bit_end      : current cycle is phase 1 of a bit
//   o_rx_byte[7:0] : last seven sampled bits plus the live MISO bit
// -----------------------------------------------------------------------------
module spi_bit_engine
  import spi_rom_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [PRE_BITS-1:0] i_word,
  input  logic                i_stop,
  input  logic                i_miso,
  output logic                o_cs,
  output logic                o_sclk,
  output logic                o_mosi,
  output logic                o_bit_end,
  output logic [7:0]          o_rx_byte
);

  logic                r_cs;
  logic                r_phase;
  logic [PRE_BITS-1:0] r_tx;
  logic [7:0]          r_rx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs    <= 1'b0;
      r_phase <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
    end else if (i_start) begin
      r_cs    <= 1'b1;
      r_phase <= 1'b0;
      r_tx    <= i_word;
      r_rx    <= '0;
    end else if (r_cs) begin
      r_phase <= ~r_phase;
      if (r_phase) begin
        // Zero fill: once the preamble has left, MOSI idles low for the
        // dummy and data bits without any extra gating.
        r_tx <= {r_tx[PRE_BITS-2:0], 1'b0};
        r_rx <= {r_rx[6:0], i_miso};
        if (i_stop) r_cs <= 1'b0;
      end
    end
  end

  assign o_cs      = r_cs;
  assign o_sclk    = r_phase;   // phase only toggles while cs is high
  assign o_mosi    = r_tx[PRE_BITS-1];
  assign o_bit_end = r_cs & r_phase;
  // The final bit of a byte is taken straight from MISO so the byte can be
  // presented in the same cycle it completes.
  assign o_rx_byte = {r_rx[6:0], i_miso};

endmodule

// File: rtl/spi_rom_arbiter.sv
// -----------------------------------------------------------------------------
// spi_rom_arbiter
// Round-robin arbiter between two read requesters sharing one SPI ROM.
// Grants one request in IDLE, then sequences CMD -> ADDR -> [DUMMY] -> DATA
// -> GAP through spi_bit_engine and streams received bytes back.
// Build option: define SPI_ROM_ARB_FAST_READ_EN to use opcode 0Bh with eight
// dummy bits (first byte at grant+96); default is opcode 03h (grant+80).
// Parameters: LEN_W (byte-count width), CS_GAP (min cycles of cs low).
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   reqN_valid/addr/len        : read request from requester N
//   reqN_ready                 : one-cycle grant pulse to requester N
//   rd_data/valid/id/last      : received byte stream, tagged with owner
//   busy                       : FSM not in IDLE
//   spi_cs/sclk/mosi, spi_miso : SPI pins (cs active high)
// -----------------------------------------------------------------------------
module spi_rom_arbiter
  import spi_rom_pkg::*;
#(
  parameter int LEN_W  = 5,
  parameter int CS_GAP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [23:0]      req0_addr,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [23:0]      req1_addr,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_id,
  output logic             rd_last,
  output logic             busy,
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

`ifdef SPI_ROM_ARB_FAST_READ_EN
  localparam logic [7:0] OPCODE = OP_FAST_READ;
`else
  localparam logic [7:0] OPCODE = OP_READ;
`endif

  state_t           r_state;
  logic [7:0]       r_cnt;       // bit counter within a field, or gap counter
  logic [LEN_W-1:0] r_len_left;
  logic [23:0]      r_addr;
  logic             r_id;
  logic             r_rr_ptr;    // requester favoured when both are valid
  logic             r_ready0;
  logic             r_ready1;

  logic             w_grant;
  logic             w_gid;
  logic [LEN_W-1:0] w_glen;
  logic             w_start;
  logic             w_bit_end;
  logic             w_byte_end;
  logic             w_last_byte;
  logic [7:0]       w_rx_byte;

  // A sole valid requester always wins; the pointer only breaks ties.
  assign w_grant = (r_state == ST_IDLE) && (req0_valid || req1_valid);
  assign w_gid   = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;
  assign w_glen  = w_gid ? req1_len : req0_len;

  // The engine starts one cycle after the grant so cs rises after req_ready.
  assign w_start     = (r_state == ST_CMD) && (r_ready0 || r_ready1);
  assign w_byte_end  = (r_state == ST_DATA) && w_bit_end && (r_cnt == 8'd7);
  assign w_last_byte = (r_len_left == LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_len_left <= '0;
      r_addr     <= '0;
      r_id       <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_ready0   <= 1'b0;
      r_ready1   <= 1'b0;
    end else begin
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_ready0   <= ~w_gid;
            r_ready1   <= w_gid;
            r_id       <= w_gid;
            r_addr     <= w_gid ? req1_addr : req0_addr;
            r_len_left <= w_glen;
            r_rr_ptr   <= ~w_gid;
            r_cnt      <= '0;
            // A zero-length read is acknowledged but never leaves IDLE.
            if (w_glen != '0) r_state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (w_bit_end) begin
            if (r_cnt == 8'(CMD_BITS - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_ADDR;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        ST_ADDR: begin
          if (w_bit_end) begin
            if (r_cnt == 8'(ADDR_BITS - 1)) begin
              r_cnt <= '0;
`ifdef SPI_ROM_ARB_FAST_READ_EN
              r_state <= ST_DUMMY;
`else
              r_state <= ST_DATA;
`endif
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        ST_DUMMY: begin
          if (w_bit_end) begin
            if (r_cnt == 8'(DUMMY_BITS - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_DATA;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_cnt == 8'd7) begin
              r_cnt      <= '0;
              r_len_left <= r_len_left - LEN_W'(1);
              if (w_last_byte) r_state <= ST_GAP;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        ST_GAP: begin
          if (r_cnt == 8'(CS_GAP - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  spi_bit_engine u_engine (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_word    (build_preamble(OPCODE, r_addr)),
    .i_stop    (w_byte_end && w_last_byte),
    .i_miso    (spi_miso),
    .o_cs      (spi_cs),
    .o_sclk    (spi_sclk),
    .o_mosi    (spi_mosi),
    .o_bit_end (w_bit_end),
    .o_rx_byte (w_rx_byte)
  );

  assign req0_ready = r_ready0;
  assign req1_ready = r_ready1;
  assign rd_valid   = w_byte_end;
  assign rd_last    = w_byte_end && w_last_byte;
  assign rd_data    = w_byte_end ? w_rx_byte : 8'h00;
  assign rd_id      = r_id;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_rom_arbiter
// Directed self-checking bench for spi_rom_arbiter with a behavioural SPI
// ROM and a MOSI capture monitor. Expected latency and preamble follow the
// SPI_ROM_ARB_FAST_READ_EN build option.
// -----------------------------------------------------------------------------
module tb_spi_rom_arbiter;

  localparam int LEN_W  = 5;
  localparam int CS_GAP = 2;
`ifdef SPI_ROM_ARB_FAST_READ_EN
  localparam int         LAT = 96;
  localparam int         PRE = 40;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int         LAT = 80;
  localparam int         PRE = 32;
  localparam logic [7:0] OPC = 8'h03;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0]      req0_addr = '0, req1_addr = '0;
  logic [LEN_W-1:0] req0_len = '0, req1_len = '0;
  logic             req0_ready, req1_ready;
  logic [7:0]       rd_data;
  logic             rd_valid, rd_id, rd_last, busy;
  logic             spi_cs, spi_sclk, spi_mosi, spi_miso;

  spi_rom_arbiter #(.LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id), .rd_last(rd_last), .busy(busy),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ROM: bit index counts completed SPI bits since cs rose; data
  // bytes follow the preamble, MSB first.
  logic [7:0] rom_bytes [0:31];
  int rom_cnt = 0;
  always @(posedge clk) begin
    if (!spi_cs)       rom_cnt <= 0;
    else if (spi_sclk) rom_cnt <= rom_cnt + 1;
  end
  always_comb begin
    spi_miso = 1'b0;
    if (spi_cs && rom_cnt >= PRE && rom_cnt < PRE + 256)
      spi_miso = rom_bytes[(rom_cnt - PRE) / 8][7 - ((rom_cnt - PRE) % 8)];
  end

  // MOSI monitor: first 64 bits of each transaction, first bit at [63].
  logic        prev_cs  = 1'b0;
  int          mon_bits = 0;
  logic [63:0] mon_sr   = '0;
  always @(posedge clk) begin
    prev_cs <= spi_cs;
    if (spi_cs && !prev_cs) begin
      mon_bits <= 0;
      mon_sr   <= '0;
    end else if (spi_cs && spi_sclk && mon_bits < 64) begin
      mon_sr[63 - mon_bits] <= spi_mosi;
      mon_bits <= mon_bits + 1;
    end
  end

  // Per-transaction observations (written only by the test process)
  int         ev_n, cs_rise, cs_fall, viol, rdy_seen, g_cyc;
  int         ev_cyc  [0:63];
  logic [7:0] ev_data [0:63];
  logic       ev_last [0:63];
  logic       ev_id   [0:63];
  logic       g_id, g_ok;

  task automatic start_req(input logic rid, input logic [23:0] addr, input logic [LEN_W-1:0] len);
    if (rid) begin req1_valid = 1'b1; req1_addr = addr; req1_len = len; end
    else     begin req0_valid = 1'b1; req0_addr = addr; req0_len = len; end
  endtask

  task automatic wait_grant();
    g_ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        g_ok = 1'b1; g_id = req1_ready; g_cyc = cyc;
        break;
      end
    end
    if (!g_ok) begin
      n_checks++;
      $display("FAIL grant_timeout: no reqN_ready within 32 cycles");
    end
  endtask

  // Observe from the cycle after the grant until cs falls.
  task automatic collect(input int max_cyc);
    ev_n = 0; cs_rise = -1; cs_fall = -1; viol = 0; rdy_seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!spi_cs && (spi_sclk || spi_mosi)) viol++;
      if (req0_ready || req1_ready) rdy_seen++;
      if (spi_cs && cs_rise < 0) cs_rise = cyc;
      if (rd_valid && ev_n < 64) begin
        ev_cyc[ev_n] = cyc; ev_data[ev_n] = rd_data;
        ev_last[ev_n] = rd_last; ev_id[ev_n] = rd_id;
        ev_n++;
      end
      if (!spi_cs && cs_rise >= 0) begin cs_fall = cyc; break; end
    end
    if (cs_fall < 0) begin
      n_checks++;
      $display("FAIL collect_timeout: cs did not complete a pulse in %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b exp 00", {req0_ready, req1_ready});
    else n_pass++;
    n_checks++;
    if ({spi_cs, spi_sclk, spi_mosi, rd_valid, rd_last, rd_id, busy, rd_data} !== 15'h0)
      $display("FAIL reset_outputs: got %h exp 0", {spi_cs, spi_sclk, spi_mosi, rd_valid, rd_last, rd_id, busy, rd_data});
    else n_pass++;
    req0_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, req0_ready, req1_ready, spi_cs} !== 4'b0000)
      $display("FAIL reset_release_idle: got %b exp 0000", {busy, req0_ready, req1_ready, spi_cs});
    else n_pass++;
  endtask

  task automatic test_single_read();
    rom_bytes[0] = 8'hA5; rom_bytes[1] = 8'h3C;
    start_req(1'b0, 24'h000120, 5'd2);
    wait_grant();
    req0_valid = 1'b0;
    if (g_ok) begin
      n_checks++;
      if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL single_grant: got %b exp 01", {req1_ready, req0_ready});
      else n_pass++;
      collect(400);
      n_checks++;
      if (rdy_seen !== 0) $display("FAIL single_ready_pulse: extra ready cycles %0d exp 0", rdy_seen);
      else n_pass++;
      n_checks++;
      if (cs_rise !== g_cyc + 1) $display("FAIL single_cs_rise: got %0d exp %0d", cs_rise - g_cyc, 1);
      else n_pass++;
      n_checks++;
      if (mon_sr[63:32] !== {OPC, 24'h000120}) $display("FAIL single_preamble: got %h exp %h", mon_sr[63:32], {OPC, 24'h000120});
      else n_pass++;
      n_checks++;
      if (mon_sr[31:24] !== 8'h00) $display("FAIL single_mosi_after_addr: got %h exp 00", mon_sr[31:24]);
      else n_pass++;
      n_checks++;
      if (ev_n !== 2) $display("FAIL single_count: got %0d exp 2", ev_n);
      else n_pass++;
      n_checks++;
      if (ev_cyc[0] - g_cyc !== LAT) $display("FAIL single_latency: got %0d exp %0d", ev_cyc[0] - g_cyc, LAT);
      else n_pass++;
      n_checks++;
      if (ev_cyc[1] - ev_cyc[0] !== 16) $display("FAIL single_spacing: got %0d exp 16", ev_cyc[1] - ev_cyc[0]);
      else n_pass++;
      n_checks++;
      if ({ev_data[0], ev_data[1]} !== 16'hA53C) $display("FAIL single_data: got %h exp a53c", {ev_data[0], ev_data[1]});
      else n_pass++;
      n_checks++;
      if ({ev_last[0], ev_last[1], ev_id[0], ev_id[1]} !== 4'b0100)
        $display("FAIL single_last_id: got %b exp 0100", {ev_last[0], ev_last[1], ev_id[0], ev_id[1]});
      else n_pass++;
      n_checks++;
      if (cs_fall !== ev_cyc[1] + 1) $display("FAIL single_cs_fall: got %0d exp %0d", cs_fall, ev_cyc[1] + 1);
      else n_pass++;
      n_checks++;
      if (viol !== 0) $display("FAIL single_idle_pins: got %0d violations exp 0", viol);
      else n_pass++;
    end
  endtask

  task automatic test_len_zero();
    int cs_hi;
    start_req(1'b1, 24'h000040, 5'd0);
    wait_grant();
    req1_valid = 1'b0;
    if (g_ok) begin
      n_checks++;
      if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL zero_grant: got %b exp 10", {req1_ready, req0_ready});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({busy, req1_ready} !== 2'b00) $display("FAIL zero_idle_next: got %b exp 00", {busy, req1_ready});
      else n_pass++;
      cs_hi = 0;
      for (int i = 0; i < 8; i++) begin
        if (spi_cs || busy) cs_hi++;
        @(negedge clk);
      end
      n_checks++;
      if (cs_hi !== 0) $display("FAIL zero_no_spi: got %0d active cycles exp 0", cs_hi);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] ids;
    int prev_fall;
    ids = 3'b111; prev_fall = -1;
    rom_bytes[0] = 8'h5A;
    start_req(1'b0, 24'h000100, 5'd1);
    start_req(1'b1, 24'h000200, 5'd1);
    for (int r = 0; r < 3; r++) begin
      wait_grant();
      if (!g_ok) break;
      ids[r] = g_id;
      if (r == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      collect(300);
      n_checks++;
      if (mon_sr[63:32] !== {OPC, (g_id ? 24'h000200 : 24'h000100)})
        $display("FAIL rr_preamble_%0d: got %h exp %h", r, mon_sr[63:32], {OPC, (g_id ? 24'h000200 : 24'h000100)});
      else n_pass++;
      n_checks++;
      if ({ev_n, ev_id[0], ev_data[0]} !== {32'd1, g_id, 8'h5A})
        $display("FAIL rr_data_%0d: got n=%0d id=%b data=%h exp n=1 id=%b data=5a", r, ev_n, ev_id[0], ev_data[0], g_id);
      else n_pass++;
      if (r > 0) begin
        n_checks++;
        if (cs_rise - prev_fall < CS_GAP) $display("FAIL rr_cs_gap_%0d: got %0d exp >= %0d", r, cs_rise - prev_fall, CS_GAP);
        else n_pass++;
      end
      prev_fall = cs_fall;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (ids !== 3'b010) $display("FAIL rr_order: got %b (r2 r1 r0) exp 010", ids);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    rom_bytes[0] = 8'hC3;
    start_req(1'b1, 24'h00ABCD, 5'd3);
    wait_grant();
    req1_valid = 1'b0;
    if (g_ok) begin
      repeat (40) @(negedge clk);
      n_checks++;
      if ({spi_cs, busy, rd_id} !== 3'b111) $display("FAIL mid_precond: got %b exp 111", {spi_cs, busy, rd_id});
      else n_pass++;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({spi_cs, spi_sclk, spi_mosi, rd_valid, rd_last, rd_id, busy, req0_ready, req1_ready, rd_data} !== 17'h0)
        $display("FAIL mid_reset_outputs: got %h exp 0",
                 {spi_cs, spi_sclk, spi_mosi, rd_valid, rd_last, rd_id, busy, req0_ready, req1_ready, rd_data});
      else n_pass++;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
    end else begin
      reset = 1'b1; @(negedge clk); reset = 1'b0;
    end
    start_req(1'b1, 24'h00F00D, 5'd1);
    wait_grant();
    req1_valid = 1'b0;
    if (g_ok) begin
      collect(300);
      n_checks++;
      if (mon_sr[63:32] !== {OPC, 24'h00F00D}) $display("FAIL post_reset_preamble: got %h exp %h", mon_sr[63:32], {OPC, 24'h00F00D});
      else n_pass++;
      n_checks++;
      if ({ev_n, ev_data[0], ev_last[0], ev_id[0]} !== {32'd1, 8'hC3, 1'b1, 1'b1})
        $display("FAIL post_reset_read: got n=%0d data=%h last=%b id=%b exp n=1 data=c3 last=1 id=1",
                 ev_n, ev_data[0], ev_last[0], ev_id[0]);
      else n_pass++;
      n_checks++;
      if (ev_cyc[0] - g_cyc !== LAT) $display("FAIL post_reset_latency: got %0d exp %0d", ev_cyc[0] - g_cyc, LAT);
      else n_pass++;
    end
  endtask

  task automatic test_max_len();
    int errs, nlast;
    for (int i = 0; i < 32; i++) rom_bytes[i] = 8'(i * 37 + 11);
    start_req(1'b0, 24'hFFFF00, 5'd31);
    wait_grant();
    req0_valid = 1'b0;
    if (g_ok) begin
      collect(1500);
      n_checks++;
      if (ev_n !== 31) $display("FAIL max_count: got %0d exp 31", ev_n);
      else n_pass++;
      errs = 0; nlast = 0;
      for (int i = 0; i < ev_n && i < 31; i++) begin
        if (ev_data[i] !== 8'(i * 37 + 11)) errs++;
        if (ev_cyc[i] - g_cyc !== LAT + 16 * i) errs++;
        if (ev_last[i]) nlast++;
      end
      n_checks++;
      if (errs !== 0) $display("FAIL max_data_timing: got %0d bad bytes exp 0", errs);
      else n_pass++;
      n_checks++;
      if ({nlast, ev_last[30]} !== {32'd1, 1'b1}) $display("FAIL max_last: got %0d last pulses (31st=%b) exp 1 on 31st", nlast, ev_last[30]);
      else n_pass++;
      n_checks++;
      if (cs_fall !== ev_cyc[30] + 1) $display("FAIL max_cs_fall: got %0d exp %0d", cs_fall, ev_cyc[30] + 1);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_bytes[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_len_zero();
    test_round_robin();
    test_reset_mid();
    test_max_len();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_rom_arbiter.md
SPI_ROM_ARBITER -- requirements
Module: spi_rom_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LEN_W, 5, width of the byte-count field; maximum transfer is 2^LEN_W-1 bytes.
- CS_GAP, 2, minimum clk cycles that spi_cs stays low between transactions.
REQ-002 Clocking and reset SHALL be one clock, with reset asynchronous and active-high.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- req0_valid, in, 1, display requester wants a read.
- req0_addr, in, 24, display start byte address.
- req0_len, in, LEN_W, display byte count.
- req0_ready, out, 1, one-cycle grant pulse to requester 0.
- req1_valid, in, 1, auxiliary requester wants a read.
- req1_addr, in, 24, auxiliary start byte address.
- req1_len, in, LEN_W, auxiliary byte count.
- req1_ready, out, 1, one-cycle grant pulse to requester 1.
- rd_data, out, 8, received byte, MSB first on the wire.
- rd_valid, out, 1, rd_data is valid this cycle.
- rd_id, out, 1, requester that owns rd_data.
- rd_last, out, 1, final byte of the transaction; qualified by rd_valid.
- busy, out, 1, state is not IDLE.
- spi_cs, out, 1, chip select, active HIGH.
- spi_sclk, out, 1, registered SPI clock, clk/2.
- spi_mosi, out, 1, command/address bit out.
- spi_miso, in, 1, data bit in.

Function
REQ-004 The state machine SHALL have states IDLE, CMD, ADDR, DUMMY, DATA and GAP.
- IDLE to CMD on a grant.
- CMD (8 bits) to ADDR (24 bits).
- ADDR to DATA, or ADDR to DUMMY to DATA when fast read is configured.
- DATA to GAP after the last byte.
- GAP to IDLE after CS_GAP cycles.
REQ-005 In IDLE with any valid asserted, the block SHALL grant exactly one requester.
- The grant pulses reqN_ready for one cycle.
- The grant latches addr, len and id.
- After reset, the round-robin pointer favours req0.
REQ-006 When both requesters are valid, the block SHALL grant the one not granted most recently; a sole valid requester SHALL always be granted.
REQ-007 A request with len=0 SHALL be acknowledged, produce no SPI activity, and leave the block in IDLE on the next cycle.
REQ-008 Each SPI bit SHALL occupy two clk cycles.
- Phase 0: spi_sclk=0 and spi_mosi is updated.
- Phase 1: spi_sclk=1.
- spi_miso is sampled on the clk edge ending phase 1.
REQ-009 spi_cs SHALL rise in the cycle after the grant and fall in the cycle after the last DATA bit's phase 1.
REQ-010 The preamble SHALL be sent MSB first: opcode 8'h03, then addr[23:0].
REQ-011 The first rd_valid SHALL occur 80 cycles after the req_ready cycle, and subsequent rd_valid pulses SHALL occur every 16 cycles.
REQ-012 rd_last SHALL coincide with the len-th rd_valid; rd_id SHALL be stable for the whole transaction.
REQ-013 spi_mosi SHALL be 0 in DUMMY, DATA, GAP and IDLE; spi_sclk SHALL be 0 whenever spi_cs=0.
REQ-014 Requests SHALL NOT be accepted outside IDLE; valid held during a transaction SHALL simply wait.

Reset
REQ-015 Asserting reset, including mid-transaction, SHALL asynchronously force the following:
- spi_cs=0, spi_sclk=0, spi_mosi=0;
- rd_valid=0, rd_last=0, rd_id=0, rd_data=0;
- req0_ready=0, req1_ready=0, busy=0;
- state IDLE, pointer to req0.
REQ-016 After reset deasserts, the first grant SHALL occur no earlier than the first clk edge on which a valid is sampled.

Configuration
REQ-017 Macro SPI_ROM_ARB_FAST_READ_EN SHALL select the read command.
- Defined: opcode 8'h0B plus 8 dummy bits (DUMMY state), giving first rd_valid 96 cycles after grant.
- Undefined: opcode 8'h03, DUMMY never entered, latency 80 cycles.

Structure
REQ-018 Package spi_rom_pkg SHALL hold the following:
- state enumeration;
- opcodes READ=8'h03 and FAST_READ=8'h0B;
- CMD_BITS=8, ADDR_BITS=24, DUMMY_BITS=8.
REQ-019 The two-phase bit timing and the 32-bit shift registers SHALL reside in sub-module spi_bit_engine; arbitration and sequencing SHALL remain in the top module.

Verification
REQ-020 Single req0 (addr 24'h000120, len 2), ROM model returning A5h then 3Ch:
- MOSI carries 03h,00h,01h,20h;
- rd_data A5h appears at grant+80 and 3Ch at grant+96;
- rd_last=1 on the second byte, rd_id=0.
REQ-021 req0 and req1 valid in the same cycle, repeated three times: grants SHALL follow 0,1,0, with at least CS_GAP=2 cycles of spi_cs=0 between transactions.
REQ-022 req1 with len=0: req1_ready pulses, spi_cs stays 0, busy=0 on the next cycle.
REQ-023 reset asserted at grant+40 (mid-ADDR): all outputs return to reset values immediately; a new req1 afterwards completes normally.
REQ-024 Fast read (SPI_ROM_ARB_FAST_READ_EN defined), len 1: MOSI carries 0Bh, address and 8 zero dummy bits; rd_valid appears at grant+96.
REQ-025 Maximum len of 31: exactly 31 rd_valid pulses, rd_last only on the 31st, spi_cs falls one cycle later.
